alu_iter: RTL and testbench
===========================

ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning operand/result width, legal 8..64, power of two.
REQ-002 The block SHALL have parameter SHAMT_W, default $clog2(XLEN), meaning shift-amount bits taken from op2.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, meaning reset, asynchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1, meaning a request is presented.
REQ-006 The block SHALL have port in_ready, output, 1, meaning the request is accepted this cycle.
REQ-007 The block SHALL have port op, input, 4, meaning the operation code.
REQ-008 The block SHALL have ports op1 and op2, input, XLEN each, meaning the operands.
REQ-009 The block SHALL have port out_valid, output, 1, meaning result holds a finished value.
REQ-010 The block SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-011 The block SHALL have port result, output, XLEN, meaning the registered result.
REQ-012 The block SHALL have port busy, output, 1, meaning state is not IDLE.

Function
REQ-013 Op codes SHALL be: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8 (signed), SLTU 9, MUL 10 (low XLEN), MULHU 11 (high XLEN, unsigned), DIVU 12, REMU 13; codes 14-15 SHALL give result 0.
REQ-014 A transfer SHALL occur on in_valid && in_ready; inputs SHALL be registered then, and ignored at all other times.
REQ-015 The FSM SHALL have states IDLE, MUL, DIV, DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 Ops 0-9 and 14-15 SHALL go IDLE->DONE on acceptance: out_valid high the cycle after acceptance (latency 1).
REQ-017 Shifts SHALL use op2[SHAMT_W-1:0] only, single-cycle barrel; SRA SHALL fill with op1[XLEN-1].
REQ-018 MUL/MULHU SHALL go IDLE->MUL, run XLEN shift-add iterations, one per cycle, on a 2*XLEN accumulator, then go to DONE: out_valid exactly XLEN+1 cycles after acceptance.
REQ-019 DIVU/REMU SHALL go IDLE->DIV, run XLEN restoring iterations, then go to DONE with the same XLEN+1 latency.
REQ-020 Divide by zero SHALL give DIVU = all ones and REMU = op1, with the same full latency.
REQ-021 The iteration counter SHALL be SHAMT_W+1 bits wide, load 0 on entry to MUL/DIV, and exit when it reaches XLEN-1.
REQ-022 In DONE, result SHALL stay stable until out_ready; DONE&&out_ready SHALL go to IDLE, with in_ready high the next cycle (no same-cycle accept).
REQ-023 Arithmetic SHALL wrap modulo 2^XLEN; no overflow flag.

Reset
REQ-024 On rst, state SHALL be IDLE, the counter 0, result 0, out_valid 0, busy 0, and in_ready 1 once rst deasserts.
REQ-025 Reset asserted mid-MUL/DIV SHALL abort the operation immediately, with no output produced.

Configuration
REQ-026 With macro ALU_ITER_MULDIV_EN defined, ops 10-13 SHALL behave per REQ-018..020.
REQ-027 Without ALU_ITER_MULDIV_EN, the MUL/DIV states and the datapath SHALL be absent, and ops 10-13 SHALL behave as ops 14-15 (result 0, latency 1).

Structure
REQ-028 Package alu_pkg SHALL hold the op-code enum and the FSM state typedef.
REQ-029 Sub-module alu_iter_mdu SHALL hold the shared multiply/divide iteration datapath, instantiated only under ALU_ITER_MULDIV_EN.

Verification
REQ-030 Test: SRA, op1=0x80000000, op2=0x24 -> result 0xF8000000 (shift 4), out_valid 1 cycle after accept.
REQ-031 Test: SLT, op1=0xFFFFFFFF, op2=1 -> 1; SLTU with the same operands -> 0.
REQ-032 Test: MULHU, op1=op2=0xFFFFFFFF -> 0xFFFFFFFE after exactly 33 cycles; MUL with the same operands -> 0x00000001.
REQ-033 Test: DIVU 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 7; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-034 Test: hold out_ready=0 for 5 cycles after ADD 3+4 -> result stays 7, in_ready stays 0, new in_valid is ignored.
REQ-035 Test: assert rst at cycle 10 of DIVU -> next cycle IDLE, out_valid 0, and a following ADD completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op-code and FSM state types for alu_iter.
// MUL/DIV states exist only when ALU_ITER_MULDIV_EN is defined.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_SLL   = 4'd5,
        OP_SRL   = 4'd6,
        OP_SRA   = 4'd7,
        OP_SLT   = 4'd8,
        OP_SLTU  = 4'd9,
        OP_MUL   = 4'd10,
        OP_MULHU = 4'd11,
        OP_DIVU  = 4'd12,
        OP_REMU  = 4'd13
    } op_e;

`ifdef ALU_ITER_MULDIV_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DONE = 2'd3
    } state_e;
`endif

endpackage

// File: rtl/alu_iter_mdu.sv
// Shared iterative multiply / restoring divide datapath for alu_iter.
// One step per cycle on a 2*XLEN accumulator; instantiated only under ALU_ITER_MULDIV_EN.
module alu_iter_mdu #(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_load,
    input  logic            i_step,
    input  logic            i_is_div,
    input  logic [XLEN-1:0] i_op1,
    input  logic [XLEN-1:0] i_op2,
    output logic [XLEN-1:0] o_lo_next,
    output logic [XLEN-1:0] o_hi_next
);

    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_b;
    logic              r_is_div;

    logic [XLEN:0]     w_add;
    logic [2*XLEN-1:0] w_mul_next;
    logic [XLEN:0]     w_rem_sh;
    logic [XLEN:0]     w_diff;
    logic [2*XLEN-1:0] w_div_next;
    logic [2*XLEN-1:0] w_next;

    // Multiply: {hi,lo} with multiplier in lo, add multiplicand to hi when lo[0], shift right.
    // Divide: {rem,quot} with dividend in quot, shift left, keep the trial subtract if non-negative.
    // A zero divisor always subtracts cleanly, leaving quot all ones and rem equal to the dividend.
    always_comb begin
        w_add      = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
        w_mul_next = {w_add, r_acc[XLEN-1:1]};
        w_rem_sh   = r_acc[2*XLEN-1:XLEN-1];
        w_diff     = w_rem_sh - {1'b0, r_b};
        if (w_diff[XLEN])
            w_div_next = {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
        else
            w_div_next = {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
        w_next = r_is_div ? w_div_next : w_mul_next;
    end

    assign o_lo_next = w_next[XLEN-1:0];
    assign o_hi_next = w_next[2*XLEN-1:XLEN];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc    <= '0;
            r_b      <= '0;
            r_is_div <= 1'b0;
        end else if (i_load) begin
            r_acc    <= {{XLEN{1'b0}}, i_op1};
            r_b      <= i_op2;
            r_is_div <= i_is_div;
        end else if (i_step) begin
            r_acc    <= w_next;
        end
    end

endmodule

// File: rtl/alu_iter.sv
// Iterative ALU: single-cycle logic/shift/compare ops, multi-cycle MUL/DIV.
// Define ALU_ITER_MULDIV_EN to enable ops 10-13; otherwise they return 0 in one cycle.
module alu_iter
    import alu_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    state_e          r_state;
    logic [XLEN-1:0] r_result;
    logic            r_in_ready;
    logic            r_out_valid;
    logic            r_busy;

    logic [XLEN-1:0]    w_simple;
    logic [SHAMT_W-1:0] w_shamt;
    logic               w_accept;

    assign w_shamt  = op2[SHAMT_W-1:0];
    assign w_accept = in_valid && r_in_ready;

    always_comb begin
        w_simple = '0;
        case (op_e'(op))
            OP_ADD:  w_simple = op1 + op2;
            OP_SUB:  w_simple = op1 - op2;
            OP_AND:  w_simple = op1 & op2;
            OP_OR:   w_simple = op1 | op2;
            OP_XOR:  w_simple = op1 ^ op2;
            OP_SLL:  w_simple = op1 << w_shamt;
            OP_SRL:  w_simple = op1 >> w_shamt;
            OP_SRA:  w_simple = $unsigned($signed(op1) >>> w_shamt);
            OP_SLT:  w_simple = XLEN'($signed(op1) < $signed(op2));
            OP_SLTU: w_simple = XLEN'(op1 < op2);
            default: w_simple = '0;
        endcase
    end

`ifdef ALU_ITER_MULDIV_EN
    localparam logic [SHAMT_W:0] CNT_LAST = (SHAMT_W+1)'(XLEN-1);

    logic [SHAMT_W:0] r_cnt;
    logic             r_hi_sel;
    logic             w_is_md;
    logic             w_mdu_load;
    logic             w_mdu_step;
    logic [XLEN-1:0]  w_mdu_lo;
    logic [XLEN-1:0]  w_mdu_hi;

    assign w_is_md    = (op >= 4'd10) && (op <= 4'd13);
    assign w_mdu_load = w_accept && w_is_md;
    assign w_mdu_step = (r_state == ST_MUL) || (r_state == ST_DIV);

    alu_iter_mdu #(
        .XLEN (XLEN)
    ) u_mdu (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_load    (w_mdu_load),
        .i_step    (w_mdu_step),
        .i_is_div  (op[2]),
        .i_op1     (op1),
        .i_op2     (op2),
        .o_lo_next (w_mdu_lo),
        .o_hi_next (w_mdu_hi)
    );
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_result    <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifdef ALU_ITER_MULDIV_EN
            r_cnt       <= '0;
            r_hi_sel    <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
`ifdef ALU_ITER_MULDIV_EN
                        // MULHU and REMU take the high half of the accumulator.
                        r_hi_sel <= op[0];
                        if (w_is_md) begin
                            r_cnt   <= '0;
                            r_state <= op[2] ? ST_DIV : ST_MUL;
                        end else begin
                            r_result    <= w_simple;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end
`else
                        r_result    <= w_simple;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
`endif
                    end
                end
`ifdef ALU_ITER_MULDIV_EN
                ST_MUL, ST_DIV: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_result    <= r_hi_sel ? w_mdu_hi : w_mdu_lo;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign busy      = r_busy;

endmodule

// File: tb/tb_alu_iter.sv
// Self-checking bench for alu_iter (XLEN=32); expectations follow ALU_ITER_MULDIV_EN when defined.
module tb_alu_iter;

`ifdef ALU_ITER_MULDIV_EN
    localparam bit MULDIV = 1'b1;
`else
    localparam bit MULDIV = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = '0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    alu_iter #(
        .XLEN (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .op1       (op1),
        .op2       (op2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input int unsigned o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int unsigned sh;
        p  = {32'h0, a} * {32'h0, b};
        sh = b % 32;
        case (o)
            0:  return a + b;
            1:  return a - b;
            2:  return a & b;
            3:  return a | b;
            4:  return a ^ b;
            5:  return a << sh;
            6:  return a >> sh;
            7:  return $unsigned($signed(a) >>> sh);
            8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            9:  return (a < b) ? 32'd1 : 32'd0;
            10: return MULDIV ? p[31:0] : 32'd0;
            11: return MULDIV ? p[63:32] : 32'd0;
            12: return MULDIV ? ((b == 0) ? 32'hFFFF_FFFF : a / b) : 32'd0;
            13: return MULDIV ? ((b == 0) ? a : a % b) : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_lat(input int unsigned o);
        return (MULDIV && o >= 10 && o <= 13) ? 33 : 1;
    endfunction

    // Drives one request from an idle DUT, returns the result and its latency (999 on timeout).
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        in_valid = 1'b1; op = o; op1 = a; op2 = b;
        @(posedge clk); #1;
        in_valid = 1'b0; op = 4'($urandom); op1 = $urandom; op2 = $urandom;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = 999;
        res = result;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || result !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: out_valid=%b busy=%b result=%h, required 0 0 00000000", out_valid, busy, result);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b busy=%b, required 1 0", in_ready, busy);
        end
    endtask

    task automatic test_directed();
        logic [3:0]  ops [10] = '{4'd7, 4'd8, 4'd9, 4'd11, 4'd10, 4'd12, 4'd13, 4'd12, 4'd13, 4'd0};
        logic [31:0] as  [10] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                  32'd7, 32'd7, 32'd100, 32'd100, 32'd3};
        logic [31:0] bs  [10] = '{32'h24, 32'd1, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                  32'd0, 32'd0, 32'd7, 32'd7, 32'd4};
        logic [31:0] exp [10] = '{32'hF800_0000, 32'd1, 32'd0, 32'hFFFF_FFFE, 32'd1,
                                  32'hFFFF_FFFF, 32'd7, 32'd14, 32'd2, 32'd7};
        logic [31:0] res;
        logic [31:0] want;
        int lat;
        for (int i = 0; i < 10; i++) begin
            want = (ops[i] >= 4'd10 && ops[i] <= 4'd13 && !MULDIV) ? 32'd0 : exp[i];
            run_op(ops[i], as[i], bs[i], res, lat);
            n_tests++;
            if (res !== want) begin
                n_fail++;
                $display("FAIL directed_result[%0d] op=%0d: got %h, required %h", i, ops[i], res, want);
            end
            n_tests++;
            if (lat != ref_lat(ops[i])) begin
                n_fail++;
                $display("FAIL directed_latency[%0d] op=%0d: got %0d, required %0d", i, ops[i], lat, ref_lat(ops[i]));
            end
        end
    endtask

    task automatic test_random();
        logic [3:0]  o;
        logic [31:0] a, b, res;
        int lat;
        for (int i = 0; i < 60; i++) begin
            o = 4'($urandom_range(15));
            a = $urandom;
            case ($urandom_range(3))
                0: b = 32'd0;
                1: b = $urandom_range(40);
                2: b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            n_tests++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL rand_ready[%0d]: in_ready=%b, required 1", i, in_ready);
            end
            run_op(o, a, b, res, lat);
            n_tests++;
            if (res !== ref_alu(o, a, b) || lat != ref_lat(o)) begin
                n_fail++;
                $display("FAIL rand_op[%0d] op=%0d a=%h b=%h: got %h lat %0d, required %h lat %0d",
                         i, o, a, b, res, lat, ref_alu(o, a, b), ref_lat(o));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] res;
        int lat;
        in_valid = 1'b1; op = 4'd0; op1 = 32'd3; op2 = 32'd4;
        @(posedge clk); #1;
        op = 4'd1; op1 = 32'd50; op2 = 32'd9;
        for (int c = 0; c < 5; c++) begin
            n_tests++;
            if (out_valid !== 1'b1 || result !== 32'd7 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold[%0d]: out_valid=%b result=%h in_ready=%b, required 1 00000007 0",
                         c, out_valid, result, in_ready);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_tests++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_release: in_ready=%b busy=%b out_valid=%b, required 1 0 0", in_ready, busy, out_valid);
        end
        @(posedge clk); #1;
        n_tests++;
        if (busy !== 1'b0 || result !== 32'd7) begin
            n_fail++;
            $display("FAIL hold_ignored: busy=%b result=%h, required 0 00000007", busy, result);
        end
        run_op(4'd4, 32'hA5A5_0F0F, 32'h0F0F_A5A5, res, lat);
        n_tests++;
        if (res !== 32'hAAAA_AAAA || lat != 1) begin
            n_fail++;
            $display("FAIL hold_next: got %h lat %0d, required aaaaaaaa lat 1", res, lat);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] res;
        int lat;
        in_valid = 1'b1; op = 4'd12; op1 = 32'd100; op2 = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        n_tests++;
        if (busy !== 1'b1 || out_valid !== !MULDIV) begin
            n_fail++;
            $display("FAIL abort_pre: busy=%b out_valid=%b, required 1 %b", busy, out_valid, !MULDIV);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_async: busy=%b out_valid=%b, required 0 0", busy, out_valid);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0) begin
            n_fail++;
            $display("FAIL abort_idle: in_ready=%b out_valid=%b result=%h, required 1 0 00000000",
                     in_ready, out_valid, result);
        end
        @(posedge clk); #1;
        run_op(4'd0, 32'd3, 32'd4, res, lat);
        n_tests++;
        if (res !== 32'd7 || lat != 1) begin
            n_fail++;
            $display("FAIL abort_next_add: got %h lat %0d, required 00000007 lat 1", res, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        int lat;
        logic [31:0] a;
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            run_op(4'(i % 2 == 0 ? 11 : 13), a, 32'(i), res, lat);
            n_tests++;
            if (res !== ref_alu(i % 2 == 0 ? 11 : 13, a, 32'(i)) || lat != ref_lat(i % 2 == 0 ? 11 : 13)) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got %h lat %0d, required %h lat %0d", i, res, lat,
                         ref_alu(i % 2 == 0 ? 11 : 13, a, 32'(i)), ref_lat(i % 2 == 0 ? 11 : 13));
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
